// File: rtl/payload_engine_ctrl.sv
// Per-packet sequencer for a bank of payload-matching engines: clears them before each
// packet, gates their enable per byte, flushes after EOP and reports matches one by one.
module payload_engine_ctrl #(
    parameter int NUM_ENG   = 32,
    parameter int ID_W      = 5,
    parameter int FLUSH_CYC = 2,
    parameter int LEN_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic               s_ready,
    output logic               eng_sod,
    output logic               eng_en,
    output logic               eng_char_zero,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               m_valid,
    output logic [ID_W-1:0]    m_id,
    output logic               m_none,
    output logic               m_last,
    output logic [LEN_W-1:0]   m_len,
    input  logic               m_ready,
    output logic               err_sop
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_FLUSH, S_REPORT} state_t;

    state_t             r_state;
    logic               r_sod;
    logic               r_err_sop;
    logic [LEN_W-1:0]   r_len;
    logic [3:0]         r_flush_cnt;
    logic [NUM_ENG-1:0] r_pend;

    logic [NUM_ENG-1:0] w_pend_drop;
    logic               w_single;
    logic               w_flushing;
    logic [ID_W-1:0]    w_low_id;

    // Clearing the lowest set bit gives both the next pending set and the "last beat" test.
    assign w_pend_drop = r_pend & (r_pend - NUM_ENG'(1));
    assign w_single    = (w_pend_drop == '0);
    assign w_flushing  = (r_state == S_FLUSH) && (r_flush_cnt != 4'd0);

    always_comb begin
        // NOTE: default first so every path assigns w_low_id and no latch is inferred.
        w_low_id = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (r_pend[i]) w_low_id = ID_W'(i);
        end
    end

    assign s_ready       = (r_state == S_IDLE) ? (s_valid & ~s_sop) : (r_state == S_SCAN);
    assign eng_en        = ((r_state == S_SCAN) & s_valid) | w_flushing;
    assign eng_char_zero = w_flushing;
    assign eng_sod       = r_sod;
    assign m_valid       = (r_state == S_REPORT);
    assign m_id          = m_valid ? w_low_id : '0;
    assign m_none        = m_valid & (r_pend == '0);
    assign m_last        = m_valid & w_single;
    assign m_len         = r_len;
    assign err_sop       = r_err_sop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: eng_sod resets high so the engines stay cleared while rst_n is low.
            r_state     <= S_IDLE;
            r_sod       <= 1'b1;
            r_err_sop   <= 1'b0;
            r_len       <= '0;
            r_flush_cnt <= 4'd0;
            r_pend      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            case (r_state)
                S_IDLE: begin
                    r_sod <= s_valid & s_sop;
                    if (s_valid && s_sop) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_sod   <= 1'b0;
                    r_len   <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (s_valid) begin
                        if (r_len != '1) r_len <= r_len + LEN_W'(1);
                        // A zero count means this is the packet's own SOP beat.
                        if (s_sop && (r_len != '0)) r_err_sop <= 1'b1;
                        if (s_eop) begin
                            r_flush_cnt <= 4'(FLUSH_CYC);
                            r_state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt != 4'd0) begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end else begin
                        r_pend  <= eng_match;
                        r_state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (m_ready) begin
                        r_pend <= w_pend_drop;
                        if (w_single) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Self-checking bench for payload_engine_ctrl: directed scenarios plus randomized packets
// compared against an expected-beat list built from the snapshot mask.
module tb_payload_engine_ctrl;

    localparam int NUM_ENG   = 32;
    localparam int ID_W      = 5;
    localparam int FLUSH_CYC = 2;
    localparam int LEN_W     = 16;

    logic               clk;
    logic               rst_n;
    logic               s_valid;
    logic               s_sop;
    logic               s_eop;
    logic               s_ready;
    logic               eng_sod;
    logic               eng_en;
    logic               eng_char_zero;
    logic [NUM_ENG-1:0] eng_match;
    logic               m_valid;
    logic [ID_W-1:0]    m_id;
    logic               m_none;
    logic               m_last;
    logic [LEN_W-1:0]   m_len;
    logic               m_ready;
    logic               err_sop;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    payload_engine_ctrl #(
        .NUM_ENG(NUM_ENG), .ID_W(ID_W), .FLUSH_CYC(FLUSH_CYC), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .eng_sod(eng_sod), .eng_en(eng_en), .eng_char_zero(eng_char_zero),
        .eng_match(eng_match),
        .m_valid(m_valid), .m_id(m_id), .m_none(m_none), .m_last(m_last),
        .m_len(m_len), .m_ready(m_ready), .err_sop(err_sop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    // Sends an n-byte packet (optional stray SOP at byte sop_at), raises mask during FLUSH,
    // then checks every result beat. abort_at >= 0 returns right after that many handshakes.
    task automatic run_pkt(input int n, input int sop_at, input logic [31:0] mask,
                           input int hold, input bit rand_ready, input int abort_at);
        int  acc, guard, sod_cnt, sod_cyc, en_cyc, eop_cyc, fl_pick, flush_en;
        int  first_mv, beat, held, exp_len, exp_id;
        bit  pres, done, exp_last;
        int  exp_ids[$];
        acc = 0; guard = 0; sod_cnt = 0; sod_cyc = -1; en_cyc = -1; eop_cyc = -1;
        flush_en = 0; first_mv = -1; beat = 0; held = 0; pres = 1'b0; done = 1'b0;
        exp_len  = (n > 65535) ? 65535 : n;
        fl_pick  = $urandom_range(0, FLUSH_CYC - 1);
        for (int i = 0; i < NUM_ENG; i++) if (mask[i]) exp_ids.push_back(i);
        eng_match = '0;

        while (acc < n && guard < 4 * n + 50) begin
            tick();
            guard++;
            if (!pres) pres = (acc == 0) || ($urandom_range(0, 3) != 0);
            s_valid = pres;
            s_sop   = pres && (acc == 0 || acc == sop_at);
            s_eop   = pres && (acc == n - 1);
            #1;
            if (eng_sod) begin sod_cnt++; sod_cyc = cyc; end
            if (eng_en && en_cyc < 0) en_cyc = cyc;
            check("en_per_byte", 64'(eng_en), 64'(s_valid & s_ready));
            if (pres && s_ready) begin
                acc++;
                pres = 1'b0;
                if (acc == n) eop_cyc = cyc;
            end
        end
        if (acc < n) begin
            check("send_timeout", 64'(acc), 64'(n));
            return;
        end
        check("sod_once", 64'(sod_cnt), 64'd1);
        check("sod_before_en", 64'(en_cyc - sod_cyc), 64'd1);

        guard = 0;
        while (!done && guard < 200) begin
            tick();
            guard++;
            idle_inputs();
            if (cyc - eop_cyc - 1 == fl_pick) eng_match = mask;
            else if (first_mv >= 0) eng_match = eng_match | $urandom();
            m_ready = (beat == 0 && held < hold) ? 1'b0
                    : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (!m_valid) begin
                if (first_mv < 0) begin
                    if (eng_en && eng_char_zero) flush_en++;
                end else begin
                    check("m_valid_drop", 64'(m_valid), 64'd1);
                    done = 1'b1;
                end
            end else begin
                if (first_mv < 0) begin
                    first_mv = cyc;
                    check("latency", 64'(cyc - eop_cyc), 64'(FLUSH_CYC + 2));
                    check("flush_en_cycles", 64'(flush_en), 64'(FLUSH_CYC));
                end
                exp_id   = (exp_ids.size() == 0) ? 0 : exp_ids[beat];
                exp_last = (exp_ids.size() == 0) || (beat == exp_ids.size() - 1);
                check("m_id", 64'(m_id), 64'(exp_id));
                check("m_none", 64'(m_none), 64'(exp_ids.size() == 0));
                check("m_last", 64'(m_last), 64'(exp_last));
                check("m_len", 64'(m_len), 64'(exp_len));
                check("report_quiet", 64'({s_ready, eng_en}), 64'd0);
                if (beat == 0 && !m_ready) held++;
                if (m_ready) begin
                    beat++;
                    if (exp_last) done = 1'b1;
                    if (abort_at >= 0 && beat == abort_at) return;
                end
            end
        end
        if (!done) check("report_timeout", 64'(beat), 64'(exp_ids.size()));
        tick();
        m_ready = 1'b0;
        #1;
        check("m_valid_after_last", 64'(m_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] mask;
        rst_n     = 1'b0;
        m_ready   = 1'b0;
        eng_match = '0;
        idle_inputs();

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sod", 64'(eng_sod), 64'd1);
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_m_valid", 64'(m_valid), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("sod_until_edge", 64'(eng_sod), 64'd1);
        tick();
        check("sod_drop", 64'(eng_sod), 64'd0);
        check("err_sop_reset", 64'(err_sop), 64'd0);

        run_pkt(40, -1, 32'h0000_0010, 0, 1'b0, -1);
        run_pkt($urandom_range(2, 30), -1, 32'h8000_0005, 3, 1'b0, -1);
        run_pkt(1, -1, 32'h0, 0, 1'b0, -1);
        check("err_sop_clean", 64'(err_sop), 64'd0);

        for (int i = 0; i < 3; i++) begin
            tick();
            s_valid = 1'b1;
            s_sop   = 1'b0;
            s_eop   = 1'($urandom_range(0, 1));
            #1;
            check("stray_ready", 64'(s_ready), 64'd1);
            check("stray_no_en", 64'(eng_en), 64'd0);
        end
        run_pkt(12, 5, $urandom(), 0, 1'b1, -1);
        check("err_sop_set", 64'(err_sop), 64'd1);

        for (int p = 0; p < 8; p++) begin
            case ($urandom_range(0, 3))
                0:       mask = 32'h0;
                1:       mask = 32'h1 << $urandom_range(0, 31);
                default: mask = $urandom();
            endcase
            run_pkt($urandom_range(1, 50), -1, mask, $urandom_range(0, 2), 1'b1, -1);
        end
        check("err_sop_sticky", 64'(err_sop), 64'd1);

        run_pkt(20, -1, 32'h0000_0111, 0, 1'b0, 1);
        tick();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        #1;
        check("abort_m_valid", 64'(m_valid), 64'd0);
        check("abort_sod", 64'(eng_sod), 64'd1);
        check("abort_err_sop", 64'(err_sop), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        #1;
        check("abort_idle", 64'(s_ready), 64'd1);
        check("abort_no_en", 64'(eng_en), 64'd0);
        run_pkt(7, -1, 32'h0400_0000, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/payload_engine_ctrl.md
Name: payload_engine_ctrl

Overview:
Per-packet sequencer for a bank of NUM_ENG payload-matching engines that share one clock, one `en` line and one `sod` clear line. It accepts payload beats from the packet parser and clears the engines before each packet. It gates the engine enable per accepted byte and flushes the engine pipelines after end-of-packet. It then snapshots the engine match outputs and reports matching rule IDs one at a time over a valid/ready handshake to the alert formatter.

Parameters:
NUM_ENG, 32, number of engines; width of eng_match.
ID_W, 5, width of m_id; must satisfy 2**ID_W >= NUM_ENG.
FLUSH_CYC, 2, enable cycles with all character lines forced low after the last byte; range 1..15.
LEN_W, 16, width of the packet byte counter.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
s_valid  in  1  payload beat valid (one byte per beat; the byte decoder sits outside).
s_sop  in  1  first beat of packet.
s_eop  in  1  last beat of packet.
s_ready  out  1  beat accepted when s_valid & s_ready.
eng_sod  out  1  registered engine clear, active high.
eng_en  out  1  engine clock enable.
eng_char_zero  out  1  decoder must force all character lines low.
eng_match  in  NUM_ENG  engine outputs (sticky end-state flops).
m_valid  out  1  result beat valid.
m_id  out  ID_W  matching engine index.
m_none  out  1  packet had no match (m_id = 0).
m_last  out  1  final result beat for the packet.
m_len  out  LEN_W  byte count of the reported packet.
m_ready  in  1  result consumer ready.
err_sop  out  1  sticky: s_sop seen inside a packet.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE, pend=0, len=0.
  - All outputs 0 except eng_sod=1, so the engines are held clear during reset.
  - eng_sod drops on the first clk edge after rst_n rises.
- FSM states: IDLE, CLEAR, SCAN, FLUSH, REPORT.
- IDLE:
  - s_ready = s_valid & ~s_sop, so stray non-sop beats are discarded with eng_en=0.
  - When s_valid & s_sop: s_ready=0 (the beat is not consumed); go to CLEAR.
- CLEAR (exactly 1 cycle):
  - eng_sod register is 1 during this cycle; len cleared.
  - Go to SCAN.
  - Purpose: the clear never coincides with the first byte's enable.
- SCAN:
  - s_ready=1; eng_en = s_valid (combinational); eng_sod=0.
  - len increments per accepted beat, saturating at all-ones.
  - Accepted beat with s_sop: treated as data; err_sop set (cleared only by reset).
  - Accepted beat with s_eop: go to FLUSH; flush counter loaded with FLUSH_CYC.
- FLUSH:
  - s_ready=0; eng_en=1; eng_char_zero=1 for FLUSH_CYC cycles.
  - On the cycle after the last flush cycle, pend <= eng_match; go to REPORT.
- REPORT:
  - s_ready=0; eng_en=0.
  - pend==0: a single beat with m_none=1, m_last=1, m_id=0.
  - Otherwise m_id = lowest set index of pend; m_last=1 iff exactly one bit is set.
  - m_len = len on every beat.
  - Handshake (m_valid & m_ready): clear the reported bit.
  - On the m_last handshake, go to IDLE in the same edge; m_valid is 0 the next cycle.
  - m_valid, m_id, m_none, m_last and m_len stay stable while m_valid & ~m_ready.
  - No combinational path from m_ready to m_valid.
- Latency:
  - eop accepted at cycle T: first m_valid at T+FLUSH_CYC+2.
  - Minimum gap between packets = report beats + FLUSH_CYC + 3 cycles.
- Match bits asserted by engines outside FLUSH are ignored until the snapshot. Bits rising during REPORT are not reported.
- Beats with s_sop & s_eop together: a 1-byte packet, normal path.
- Reset asserted mid-packet: immediate return to IDLE, eng_sod=1, pending results dropped.

Test Plan:
- Reset: rst_n low 3 cycles then released -> eng_sod=1 throughout reset, 0 one edge after release; s_ready=0, m_valid=0.
- Packet of 40 bytes, eng_match rising to 0x0000_0010 during FLUSH -> one beat m_id=4, m_last=1, m_none=0, m_len=40; eng_sod pulsed exactly once, the cycle before byte 0's eng_en.
- eng_match=0x8000_0005 with m_ready low 3 cycles on the first beat -> beats in order id 0, 2, 31; first beat held stable 3 cycles; m_last only on id 31.
- No match, 1-byte packet (sop & eop same beat) -> single beat m_none=1, m_id=0, m_len=1; first m_valid exactly FLUSH_CYC+2 cycles after eop.
- Stray beats without sop in IDLE, then sop mid-packet -> stray beats dropped with eng_en=0 and len unaffected; err_sop=1 and stays 1 until reset.
- rst_n pulsed low during REPORT with 2 results pending -> m_valid=0 immediately; FSM in IDLE; next packet reports only its own matches.
